// File: rtl/prirv32_pkg.sv
// Shared types and constants for the prirv32 instruction-fetch front end.
package prirv32_pkg;

  localparam int          RV_ILEN = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef enum logic [1:0] {
    FS_BOOT,
    FS_RUN,
    FS_DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [RV_ILEN-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

  // Clear the byte offset of an address so it points at a whole word.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/prirv32_fetch_fifo.sv
// Small synchronous FIFO with flush, occupancy count and a registered head.
// The head is kept in its own register so consumers sampling it mid-cycle
// see a clean flop output rather than a read mux over the storage array.
module prirv32_fetch_fifo
  import prirv32_pkg::*;
#(
  parameter int WIDTH = RV_ILEN,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_inc;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] head_reg;
  logic             do_push;
  logic             do_pop;

  // Qualify push/pop: flush wins, pops need data, pushes need a free slot
  always_comb begin
    do_pop     = pop && (count_reg != '0) && !flush;
    do_push    = push && !flush && ((count_reg != CW'(DEPTH)) || do_pop);
    rd_ptr_inc = rd_ptr_reg + 1'b1;
  end

  // Storage array write port
  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers, occupancy and the registered head entry
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
      // The new head is either the incoming word (queue empty or about to
      // be) or the entry behind the one being popped.
      if (do_push && ((count_reg == '0) || (do_pop && (count_reg == CW'(1))))) begin
        head_reg <= push_data;
      end else if (do_pop && (count_reg > CW'(1))) begin
        head_reg <= mem[rd_ptr_inc];
      end
    end
  end

  assign head  = head_reg;
  assign count = count_reg;

  overflow_chk: assert property (@(posedge clk_in) disable iff (!rst_n)
    !(push && !flush && (count_reg == CW'(DEPTH)) && !pop));

endmodule

// File: rtl/prirv32_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word requests over a
// req/gnt/rvalid bus, buffers returned words with their PC in an in-order
// prefetch FIFO and hands them to decode over valid/ready. A redirect
// flushes the FIFO and discards responses still in flight.
// Optional build macro PRIRV32_FETCH_MISALIGN_TRAP_EN: flags misaligned
// redirect targets (fetch_misalign_o/mtval_o) and halts fetch until an
// aligned redirect arrives; without it the low target bits are masked.
module prirv32_fetch_unit
  import prirv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_in,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
`ifdef PRIRV32_FETCH_MISALIGN_TRAP_EN
  output logic        fetch_misalign_o,
  output logic [31:0] mtval_o,
`endif
  output logic        fetch_busy_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_reg;
  logic [31:0]   pc_reg;
  logic [31:0]   pc_next;
  logic [CW-1:0] outstanding_reg;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] discard_reg;
  logic [CW-1:0] discard_next;
  logic          busy_reg;
  logic          halt;
  logic          pop;
  logic          req;
  logic          fire;
  logic          rsp_keep;
  logic          rsp_drop;
  logic [CW:0]   credit_used;
  logic [CW-1:0] data_count;
  logic [CW-1:0] tag_count;
  logic [31:0]   tag_head;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

`ifdef PRIRV32_FETCH_MISALIGN_TRAP_EN
  logic        misalign_reg;
  logic [31:0] mtval_reg;

  // Latch a misaligned redirect target; any aligned redirect clears the flag
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      misalign_reg <= 1'b0;
      mtval_reg    <= '0;
    end else if (redirect_i) begin
      misalign_reg <= |redirect_pc_i[1:0];
      if (|redirect_pc_i[1:0]) begin
        mtval_reg <= redirect_pc_i;
      end
    end
  end

  assign fetch_misalign_o = misalign_reg;
  assign mtval_o          = mtval_reg;
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc_i[1:0];
`endif

  // Request credit, handshake qualification and next-state arithmetic
  always_comb begin
    halt = 1'b0;
`ifdef PRIRV32_FETCH_MISALIGN_TRAP_EN
    halt = misalign_reg;
`endif
    pop = (data_count != '0) && instr_ready_i && !redirect_i;
    // A slot freed by a same-cycle pop is reusable immediately; without
    // this the front end could only sustain one word every other cycle.
    credit_used = {1'b0, outstanding_reg} + {1'b0, data_count} - {{CW{1'b0}}, pop};
    req = ((state_reg == FS_RUN) || (state_reg == FS_DRAIN)) && !halt && !redirect_i &&
          (credit_used < (CW + 1)'(FIFO_DEPTH));
    fire     = req && imem_gnt_i;
    rsp_keep = imem_rvalid_i && (discard_reg == '0);
    rsp_drop = imem_rvalid_i && (discard_reg != '0);
    push_entry.instr = imem_rdata_i;
    push_entry.pc    = tag_head;
    outstanding_next = outstanding_reg + CW'(fire) - CW'(imem_rvalid_i);
    if (redirect_i) begin
      // Everything still in flight after this cycle belongs to the old path
      discard_next = outstanding_reg - CW'(imem_rvalid_i);
      pc_next      = word_align(redirect_pc_i);
    end else begin
      discard_next = discard_reg - CW'(rsp_drop);
      pc_next      = fire ? pc_reg + PC_INC : pc_reg;
    end
  end

  // Program counter, in-flight/discard counters and busy flag
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg          <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      busy_reg        <= 1'b0;
    end else begin
      pc_reg          <= pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      busy_reg        <= (outstanding_next != '0) || (discard_next != '0);
    end
  end

  // Fetch state machine: one idle boot cycle, then run; drain stale data after redirects
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FS_BOOT;
    end else begin
      case (state_reg)
        FS_BOOT:  state_reg <= FS_RUN;
        FS_RUN:   if (redirect_i && (discard_next != '0)) state_reg <= FS_DRAIN;
        FS_DRAIN: if (!redirect_i && (discard_next == '0)) state_reg <= FS_RUN;
        default:  state_reg <= FS_BOOT;
      endcase
    end
  end

  // PC tags of granted requests, consumed in order as kept responses return
  prirv32_fetch_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .flush     (redirect_i),
    .push      (fire),
    .push_data (pc_reg),
    .pop       (rsp_keep),
    .head      (tag_head),
    .count     (tag_count)
  );

  // Prefetch buffer of {instruction, pc} presented to decode
  prirv32_fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_data_fifo (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .flush     (redirect_i),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (data_count)
  );

  assign imem_req_o    = req;
  assign imem_addr_o   = pc_reg;
  assign instr_valid_o = (data_count != '0);
  assign instr_o       = head_entry.instr;
  assign instr_pc_o    = head_entry.pc;
  assign fetch_busy_o  = busy_reg;

  rsp_chk: assert property (@(posedge clk_in) disable iff (!rst_n)
    imem_rvalid_i |-> (outstanding_reg != '0));
  tag_chk: assert property (@(posedge clk_in) disable iff (!rst_n)
    rsp_keep |-> (tag_count != '0));

endmodule
